// File: rtl/timer_pkg.sv
// Shared types and BCD helpers for the countdown timer control path.
// BCD pairs are packed as {tens, ones}.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSE   = 2'd2,
    EXPIRED = 2'd3
  } state_e;

  localparam logic [3:0] BCD_MAX = 4'd9;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v[3:0] >= BCD_MAX) begin
      if (v[7:4] >= BCD_MAX) return 8'h00;
      return {v[7:4] + 4'd1, 4'd0};
    end
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  // Saturates at 00 so the count can never underflow into 99.
  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    if (v[3:0] == 4'd0) begin
      if (v[7:4] == 4'd0) return 8'h00;
      return {v[7:4] - 4'd1, BCD_MAX};
    end
    return {v[7:4], v[3:0] - 4'd1};
  endfunction

endpackage

// File: rtl/timer_ctrl_fsm_if.sv
// Button inputs and display/status outputs of the timer control sequencer.
interface timer_ctrl_fsm_if;
  logic       btn_start;
  logic       btn_inc;
  logic       btn_clr;
  logic [3:0] ones;
  logic [3:0] tens;
  logic       running;
  logic       alarm;
  logic       blank;
  logic       tick;

  modport master (
    output btn_start, btn_inc, btn_clr,
    input  ones, tens, running, alarm, blank, tick
  );

  modport slave (
    input  btn_start, btn_inc, btn_clr,
    output ones, tens, running, alarm, blank, tick
  );
endinterface

// File: rtl/btn_debounce.sv
// Raw button conditioner: 2-FF synchronizer, stability debounce and a
// one-cycle press pulse on the debounced rising edge.
module btn_debounce #(
  parameter int DEBOUNCE_CYC = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYC > 0) ? $clog2(DEBOUNCE_CYC + 1) : 1;

  logic          sync1_q, sync2_q;
  logic          level_q, level_dly_q, press_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          differ, accept;

  // The counter only runs while the synced level disagrees with the accepted one.
  always_comb begin
    differ = (sync2_q != level_q);
    accept = differ && (cnt_q == CW'(DEBOUNCE_CYC - 1));
    cnt_d  = '0;
    if (differ && !accept) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
      press_q     <= 1'b0;
      cnt_q       <= '0;
    end else begin
      sync1_q     <= raw;
      sync2_q     <= sync1_q;
      cnt_q       <= cnt_d;
      if (accept) level_q <= sync2_q;
      level_dly_q <= level_q;
      press_q     <= level_q & ~level_dly_q;
    end
  end

  assign level = level_q;
  assign press = press_q;

endmodule

// File: rtl/timer_ctrl_fsm.sv
// Countdown timer sequencer: button conditioning, BCD count, 1 s prescaler,
// IDLE/RUN/PAUSE/EXPIRED control and alarm/blink outputs.
module timer_ctrl_fsm
  import timer_pkg::*;
#(
  parameter int TICK_DIV     = 6000000,
  parameter int DEBOUNCE_CYC = 50000,
  parameter int ALARM_TICKS  = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  timer_ctrl_fsm_if.slave  bus
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int AW = $clog2(ALARM_TICKS + 1);

  logic          press_start, press_inc, press_clr;
  logic          do_clr, do_start, do_inc, any_press;
  state_e        state_q;
  logic [7:0]    cnt_q, cnt_up_d, cnt_dn_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          presc_wrap;
  logic [AW-1:0] acnt_q;
  logic          acnt_last;
  logic          running_q, alarm_q, blank_q, tick_q;

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_start (
    .clk(clk), .rst_n(rst_n), .raw(bus.btn_start), .level(), .press(press_start));
  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_inc (
    .clk(clk), .rst_n(rst_n), .raw(bus.btn_inc), .level(), .press(press_inc));
  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_clr (
    .clk(clk), .rst_n(rst_n), .raw(bus.btn_clr), .level(), .press(press_clr));

  // Same-cycle presses resolve clr > start > inc; the losers are discarded.
  assign do_clr    = press_clr;
  assign do_start  = press_start & ~press_clr;
  assign do_inc    = press_inc & ~press_clr & ~press_start;
  assign any_press = press_clr | press_start | press_inc;

  assign presc_wrap = (presc_q == PW'(TICK_DIV - 1));
  assign presc_d    = presc_wrap ? '0 : presc_q + 1'b1;
  assign acnt_last  = (acnt_q == AW'(ALARM_TICKS - 1));
  assign cnt_up_d   = bcd_inc(cnt_q);
  assign cnt_dn_d   = bcd_dec(cnt_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      presc_q   <= '0;
      acnt_q    <= '0;
      running_q <= 1'b0;
      alarm_q   <= 1'b0;
      blank_q   <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      case (state_q)
        IDLE: begin
          presc_q <= '0;
          if (do_clr) cnt_q <= '0;
          else if (do_start && cnt_q != 8'h00) begin
            state_q   <= RUN;
            running_q <= 1'b1;
          end else if (do_inc) cnt_q <= cnt_up_d;
        end
        RUN: begin
          if (do_clr) begin
            state_q   <= IDLE;
            running_q <= 1'b0;
            cnt_q     <= '0;
            presc_q   <= '0;
          end else if (do_start) begin
            state_q   <= PAUSE;
            running_q <= 1'b0;
          end else begin
            presc_q <= presc_d;
            if (presc_wrap) begin
              tick_q <= 1'b1;
              cnt_q  <= cnt_dn_d;
              if (cnt_dn_d == 8'h00) begin
                state_q   <= EXPIRED;
                running_q <= 1'b0;
                alarm_q   <= 1'b1;
              end
            end
          end
        end
        PAUSE: begin
          if (do_clr) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            presc_q <= '0;
          end else if (do_start) begin
            state_q   <= RUN;
            running_q <= 1'b1;
          end else if (do_inc) cnt_q <= cnt_up_d;
        end
        EXPIRED: begin
          // The final alarm tick still pulses tick; a button press cancels silently.
          if (any_press || (presc_wrap && acnt_last)) begin
            state_q <= IDLE;
            alarm_q <= 1'b0;
            blank_q <= 1'b0;
            acnt_q  <= '0;
            cnt_q   <= '0;
            presc_q <= '0;
            tick_q  <= presc_wrap & ~any_press;
          end else begin
            presc_q <= presc_d;
            if (presc_wrap) begin
              tick_q  <= 1'b1;
              blank_q <= ~blank_q;
              acnt_q  <= acnt_q + 1'b1;
            end
          end
        end
      endcase
      if (cnt_q[3:0] > BCD_MAX) cnt_q[3:0] <= '0;
      if (cnt_q[7:4] > BCD_MAX) cnt_q[7:4] <= '0;
    end
  end

  assign bus.ones    = cnt_q[3:0];
  assign bus.tens    = cnt_q[7:4];
  assign bus.running = running_q;
  assign bus.alarm   = alarm_q;
  assign bus.blank   = blank_q;
  assign bus.tick    = tick_q;

endmodule

// File: tb/tb_timer_ctrl_fsm.sv
// Randomized and directed bench for timer_ctrl_fsm against a cycle-level
// behavioural model (integer count, sample-window debounce).
module tb_timer_ctrl_fsm;

  localparam int TD  = 10;
  localparam int DEB = 4;
  localparam int AT  = 3;
  localparam int HN  = DEB + 2;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_EXP = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  timer_ctrl_fsm_if bus();

  timer_ctrl_fsm #(.TICK_DIV(TD), .DEBOUNCE_CYC(DEB), .ALARM_TICKS(AT)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  // Model state: count as 0..99, buttons as raw sample history.
  int m_mode, m_cnt, m_presc, m_acnt;
  bit m_blank, m_tick;
  bit hist [3][HN];
  bit lvl [3];
  bit r1 [3];
  bit r2 [3];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void m_reset();
    m_mode = M_IDLE; m_cnt = 0; m_presc = 0; m_acnt = 0;
    m_blank = 1'b0; m_tick = 1'b0;
    for (int b = 0; b < 3; b++) begin
      lvl[b] = 1'b0; r1[b] = 1'b0; r2[b] = 1'b0;
      for (int k = 0; k < HN; k++) hist[b][k] = 1'b0;
    end
  endfunction

  // raw bit order: 0=start, 1=inc, 2=clr
  function automatic void m_step(input logic [2:0] raw);
    bit pr [3];
    bit c, s, i, any, same, v;
    for (int b = 0; b < 3; b++) begin
      pr[b] = r2[b];
      r2[b] = r1[b];
      for (int k = HN - 1; k > 0; k--) hist[b][k] = hist[b][k-1];
      hist[b][0] = raw[b];
      // Level follows once the synchronized input held one value for DEB samples.
      v = hist[b][2];
      same = 1'b1;
      for (int k = 3; k < HN; k++) if (hist[b][k] != v) same = 1'b0;
      r1[b] = same && v && !lvl[b];
      if (same) lvl[b] = v;
    end
    c = pr[2];
    s = pr[0] && !c;
    i = pr[1] && !c && !pr[0];
    any = pr[0] || pr[1] || pr[2];
    m_tick = 1'b0;
    case (m_mode)
      M_IDLE: begin
        m_presc = 0;
        if (c) m_cnt = 0;
        else if (s) begin if (m_cnt != 0) m_mode = M_RUN; end
        else if (i) m_cnt = (m_cnt + 1) % 100;
      end
      M_RUN: begin
        if (c) begin m_mode = M_IDLE; m_cnt = 0; m_presc = 0; end
        else if (s) m_mode = M_PAUSE;
        else if (m_presc == TD - 1) begin
          m_presc = 0; m_tick = 1'b1;
          if (m_cnt <= 1) begin m_cnt = 0; m_mode = M_EXP; end
          else m_cnt = m_cnt - 1;
        end else m_presc++;
      end
      M_PAUSE: begin
        if (c) begin m_mode = M_IDLE; m_cnt = 0; m_presc = 0; end
        else if (s) m_mode = M_RUN;
        else if (i) m_cnt = (m_cnt + 1) % 100;
      end
      default: begin
        if (any) begin
          m_mode = M_IDLE; m_cnt = 0; m_presc = 0; m_acnt = 0; m_blank = 1'b0;
        end else if (m_presc == TD - 1) begin
          m_presc = 0; m_tick = 1'b1;
          if (m_acnt == AT - 1) begin
            m_mode = M_IDLE; m_cnt = 0; m_acnt = 0; m_blank = 1'b0;
          end else begin
            m_blank = !m_blank; m_acnt++;
          end
        end else m_presc++;
      end
    endcase
  endfunction

  task automatic check_all();
    chk("ones", bus.ones, m_cnt % 10);
    chk("tens", bus.tens, m_cnt / 10);
    chk("running", bus.running, m_mode == M_RUN);
    chk("alarm", bus.alarm, m_mode == M_EXP);
    chk("blank", bus.blank, m_blank);
    chk("tick", bus.tick, m_tick);
  endtask

  task automatic cyc();
    logic [2:0] r;
    r = {bus.btn_clr, bus.btn_inc, bus.btn_start};
    @(posedge clk);
    #1;
    if (!rst_n) m_reset();
    else m_step(r);
    check_all();
  endtask

  task automatic set_btn(input int b, input bit v);
    case (b)
      0: bus.btn_start = v;
      1: bus.btn_inc   = v;
      default: bus.btn_clr = v;
    endcase
  endtask

  task automatic hold(input int b, input int n);
    set_btn(b, 1'b1);
    repeat (n) cyc();
    set_btn(b, 1'b0);
    repeat (8) cyc();
  endtask

  task automatic press_n(input int b, input int k);
    repeat (k) hold(b, 6);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int hc [3];
    bit bv [3];
    bit reached;
    bus.btn_start = 1'b0;
    bus.btn_inc   = 1'b0;
    bus.btn_clr   = 1'b0;
    m_reset();
    repeat (3) cyc();
    @(negedge clk);
    rst_n = 1'b1;

    // Count 03 down to expiry, alarm blink, auto-return.
    press_n(1, 3);
    hold(0, 6);
    repeat (90) cyc();

    // Start with 00 is ignored.
    hold(0, 6);
    repeat (30) cyc();

    // Pause mid-second and resume from the held prescaler.
    press_n(1, 10);
    hold(0, 6);
    reached = 1'b0;
    for (int g = 0; g < 100 && !reached; g++) begin
      if (m_mode == M_RUN && m_presc == 2) reached = 1'b1;
      else cyc();
    end
    chk("sync_run", {31'b0, reached}, 1);
    hold(0, 5);
    repeat (20) cyc();
    hold(0, 6);
    repeat (30) cyc();

    // 99 wraps to 00, then simultaneous presses in RUN.
    hold(2, 6);
    press_n(1, 100);
    press_n(1, 2);
    hold(0, 6);
    bus.btn_start = 1'b1; bus.btn_inc = 1'b1; bus.btn_clr = 1'b1;
    repeat (6) cyc();
    bus.btn_start = 1'b0; bus.btn_inc = 1'b0; bus.btn_clr = 1'b0;
    repeat (20) cyc();

    // Short glitch rejected, full hold accepted once.
    hold(1, 3);
    repeat (10) cyc();
    hold(1, 6);
    repeat (10) cyc();

    // Asynchronous reset while running.
    press_n(1, 5);
    hold(0, 6);
    repeat (15) cyc();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    m_reset();
    check_all();
    repeat (2) cyc();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) cyc();

    // Random button traffic with glitches and overlapping presses.
    for (int b = 0; b < 3; b++) begin
      bv[b] = 1'b0;
      hc[b] = $urandom_range(5, 30);
    end
    for (int t = 0; t < 4000; t++) begin
      for (int b = 0; b < 3; b++) begin
        if (hc[b] == 0) begin
          bv[b] = !bv[b];
          if (bv[b]) hc[b] = $urandom_range(1, 9);
          else if (b == 0) hc[b] = $urandom_range(20, 150);
          else if (b == 1) hc[b] = $urandom_range(4, 40);
          else hc[b] = $urandom_range(80, 400);
          set_btn(b, bv[b]);
        end else hc[b]--;
      end
      cyc();
    end

    bus.btn_start = 1'b0; bus.btn_inc = 1'b0; bus.btn_clr = 1'b0;
    repeat (10) cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
